fb_sdram_arbiter: RTL

- Shares the single FPGA SDRAM Avalon-MM master port (framebuffer/stroke memory) between three requesters:
  - VGA line-prefetch reads (rd_*).
  - Local touchscreen stroke writes (w0_*).
  - Remote wifi stroke writes (w1_*).
- Reads have priority, with a starvation guard for writes.
- Writes are round-robin between the two write ports.
- Tracks pipelined read responses and returns read data to the prefetch port.

---
 rtl/fb_sdram_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fb_sdram_arbiter.sv
// Arbitrates one SDRAM Avalon-MM master between VGA prefetch reads and two stroke-write ports.
// Reads take priority behind a starvation guard; writes alternate round-robin; read data returns in order.
module fb_sdram_arbiter #(
    parameter int ADDR_W          = 25,
    parameter int DATA_W          = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    input  logic              w0_valid,
    input  logic [ADDR_W-1:0] w0_addr,
    input  logic [DATA_W-1:0] w0_data,
    output logic              w0_ready,
    input  logic              w1_valid,
    input  logic [ADDR_W-1:0] w1_addr,
    input  logic [DATA_W-1:0] w1_data,
    output logic              w1_ready,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [DATA_W-1:0] m_writedata,
    input  logic              m_waitrequest,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_readdatavalid,
    output logic [2:0]        outstanding,
    output logic              err_underflow
);
    localparam int             SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [2:0]     MAX_OUT    = 3'(MAX_OUTSTANDING);
    localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t              r_state, w_state_nxt;
    logic [SW-1:0]       r_starve;
    logic                r_last_w1;
    logic [2:0]          r_outstanding;
    logic                r_err;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_read, r_write;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_data_valid;

    logic w_rd_elig, w_wr_any, w_pick_w1, w_starved;
    logic w_gnt_rd, w_gnt_wr, w_rd_acc;

    always_comb begin
        w_rd_elig   = rd_valid && (r_outstanding < MAX_OUT);
        w_wr_any    = w0_valid || w1_valid;
        // With both writers waiting, the one not granted last goes next.
        w_pick_w1   = w1_valid && (!w0_valid || !r_last_w1);
        w_starved   = (r_starve == STARVE_MAX);
        w_rd_acc    = (r_state == S_ISSUE) && r_read && !m_waitrequest;
        w_gnt_rd    = 1'b0;
        w_gnt_wr    = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_starved && w_wr_any) w_gnt_wr = 1'b1;
                else if (w_rd_elig)        w_gnt_rd = 1'b1;
                else if (w_wr_any)         w_gnt_wr = 1'b1;
                if (w_gnt_rd || w_gnt_wr) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: if (!m_waitrequest) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_state         <= S_IDLE;
            r_starve        <= '0;
            r_last_w1       <= 1'b1;
            r_outstanding   <= '0;
            r_err           <= 1'b0;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_read          <= 1'b0;
            r_write         <= 1'b0;
            r_rd_data       <= '0;
            r_rd_data_valid <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_rd_data       <= m_readdata;
            r_rd_data_valid <= m_readdatavalid;
            if (r_state == S_IDLE) begin
                if (w_gnt_rd) begin
                    r_addr <= rd_addr;
                    r_read <= 1'b1;
                end
                if (w_gnt_wr) begin
                    r_addr    <= w_pick_w1 ? w1_addr : w0_addr;
                    r_wdata   <= w_pick_w1 ? w1_data : w0_data;
                    r_write   <= 1'b1;
                    r_last_w1 <= w_pick_w1;
                end
                if (w_gnt_wr || !w_wr_any) r_starve <= '0;
                else if (w_gnt_rd && !w_starved) r_starve <= r_starve + SW'(1);
            end else if (!m_waitrequest) begin
                r_read  <= 1'b0;
                r_write <= 1'b0;
            end
            // A response with nothing in flight is bogus: flag it and do not let it cancel a new accept.
            if (m_readdatavalid && r_outstanding == 3'd0) begin
                r_err <= 1'b1;
                if (w_rd_acc) r_outstanding <= 3'd1;
            end else if (w_rd_acc && !m_readdatavalid) begin
                r_outstanding <= r_outstanding + 3'd1;
            end else if (!w_rd_acc && m_readdatavalid) begin
                r_outstanding <= r_outstanding - 3'd1;
            end
        end
    end

    assign rd_ready      = w_gnt_rd;
    assign w0_ready      = w_gnt_wr && !w_pick_w1;
    assign w1_ready      = w_gnt_wr && w_pick_w1;
    assign m_address     = r_addr;
    assign m_writedata   = r_wdata;
    assign m_read        = r_read;
    assign m_write       = r_write;
    assign outstanding   = r_outstanding;
    assign err_underflow = r_err;
    assign rd_data       = r_rd_data;
    assign rd_data_valid = r_rd_data_valid;
endmodule
